tmr_bank_apb: RTL
=================

// Module: tmr_bank_apb
// PURPOSE
//  APB slave holding CH_N IEC 61131-3 timer channels (TON/TOF/TP) plus a shared tick prescaler.
//  Each channel has its own TYPE/PT/IN registers and its own ET/Q state.
//  Replaces the single-timer decoder-plus-timer pair on the PLC peripheral bus.
//  Zero-wait APB reads; ET advances one count per prescaler tick.
// PARAMETERS
//  CH_N       4      number of timer channels, 1..16
//  APB_ADDR_W 16     APB address width
//  PRESC_DIV  1000   pclk cycles per tick (>=1); 1 = tick every cycle
// PORTS
//  pclk        in   1          APB/system clock
//  presetn     in   1          async active-low reset
//  paddr       in   APB_ADDR_W word address: [2:0] reg, [6:3] channel
//  psel        in   1          APB select
//  penable     in   1          APB access phase
//  pwrite      in   1          1 = write
//  pwdata      in   32         write data
//  prdata      out  32         read data (combinational from paddr)
//  pready      out  1          tied 1
//  pslverr     out  1          1 in access phase for channel >= CH_N or reg 6/7
//  tmr_q       out  CH_N       Q of every channel, for direct PLC I/O mapping
//  irq         out  1          OR of IRQ flags (TMR_IRQ_EN only)
// BEHAVIOUR
//  Reset: all regs, ET, Q, state, prescaler, irq = 0; TYPE = 3 (idle); prdata follows paddr.
//  Write strobe: psel&penable&pwrite, applied on the rising pclk edge; writes with pslverr set are dropped.
//  Reg map: 0 TYPE[1:0] RW (0 TON, 1 TOF, 2 TP, 3 idle); 1 PT[31:0] RW; 2 IN[0] RW;
//    3 Q[0] RO; 4 ET[31:0] RO; 5 IRQ flag[0] W1C. Writes to RO regs are ignored, no error.
//  Unused prdata bits read 0.
//  Prescaler: free-running 0..PRESC_DIV-1; tick = 1 for one cycle when the count == PRESC_DIV-1.
//  Channel update each cycle uses IN/PT as registered at cycle start; a new IN is seen one cycle after its write.
//  TON: IN=0 -> ET=0, Q=0. IN=1 -> ET+1 per tick while ET<PT; Q=1 once ET==PT. PT=0 -> Q=1 the cycle after IN=1.
//  TOF: IN=1 -> ET=0, Q=1. IN=0 -> ET+1 per tick while ET<PT; Q=0 once ET==PT; IN back to 1 restarts.
//    After reset with IN=0, Q=0 and ET=0 (no spurious pulse).
//  TP FSM: IDLE -(IN rising)-> PULSE (ET=0, Q=1); PULSE: ET+1 per tick, IN changes ignored,
//    at ET==PT -> DONE (Q=0, ET holds PT); DONE -(IN=0)-> IDLE (ET=0). PT=0: pulse lasts 1 cycle.
//  ET saturates at PT and never wraps. PT written below current ET -> ET clamps to PT next cycle and the end condition fires.
//  TYPE write: channel state, ET and Q clear the next cycle, then the new mode runs; IN keeps its value.
//  Idle (TYPE=3): ET=0, Q=0, no counting.
//  Q/ET/state are registered; tmr_q == per-channel Q register.
//  presetn low mid-count: immediate async clear to reset values; counting restarts from 0 after release.
// CONFIGURATION
//  TMR_IRQ_EN defined: per-channel flag set on Q rising edge (0->1); W1C via reg 5.
//    Set wins over clear in the same cycle. irq = OR of flags, registered.
//  TMR_IRQ_EN undefined: no flag logic; reg 5 reads 0, writes ignored; irq tied 0.
// TESTING (PRESC_DIV=4, CH_N=4)
//  TON ch0, PT=3, IN=1 -> ET 1,2,3 at ticks; Q=1 one cycle after ET=3; IN=0 -> ET=0, Q=0 next cycle.
//  TOF ch1, PT=2: IN=1 then 0 -> Q stays 1 for 2 ticks, then Q=0, ET=2; IN=1 -> Q=1, ET=0.
//  TP ch2, PT=5: IN pulses 1/0/1 mid-pulse -> single Q pulse, 5 ticks, ET holds 5 until IN=0.
//  Read reg 0 of ch 7 -> pslverr=1, prdata=0; write PT ch 7 -> no channel changes.
//  presetn low during TON count ET=2 -> ET=0, Q=0, TYPE=3 immediately; regs read reset values.
//  TMR_IRQ_EN: TON ch3, PT=1 -> irq=1 after Q rises; write reg5=1 -> irq=0; reg5 reads 0 when undefined.

Source files
------------

// File: rtl/tmr_bank_apb.sv
// tmr_bank_apb: APB slave with CH_N IEC 61131-3 timer channels (TON/TOF/TP)
// that share one tick prescaler. Each channel has TYPE/PT/IN registers and
// its own ET/Q/TP state.
//
// Ports:
//   pclk, presetn        clock, async active-low reset
//   paddr                word address: [2:0] register, [6:3] channel
//   psel/penable/pwrite  APB control; pwdata write data
//   prdata               read data, combinational from paddr
//   pready               always 1 (zero wait states)
//   pslverr              access-phase error for channel >= CH_N or reg 6/7
//   tmr_q                Q of every channel
//   irq                  OR of per-channel IRQ flags
//
// Register map (per channel):
//   0 TYPE[1:0] RW  (0 TON, 1 TOF, 2 TP, 3 idle)
//   1 PT[31:0]  RW
//   2 IN[0]     RW
//   3 Q[0]      RO
//   4 ET[31:0]  RO
//   5 IRQ flag  W1C
//
// Build option: define TMR_IRQ_EN to add the per-channel Q-rise flags and
// the irq output. Without it reg 5 reads 0, writes to it are ignored and
// irq is tied 0.

module tmr_bank_apb #(
  parameter int unsigned CH_N       = 4,
  parameter int unsigned APB_ADDR_W = 16,
  parameter int unsigned PRESC_DIV  = 1000
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic [APB_ADDR_W-1:0] paddr,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [31:0]           pwdata,
  output logic [31:0]           prdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic [CH_N-1:0]       tmr_q,
  output logic                  irq
);

  localparam int unsigned DW = 32;
  localparam int unsigned RW = 3;
  localparam int unsigned CW = 4;
  localparam int unsigned PW = (PRESC_DIV > 1) ? $clog2(PRESC_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC_DIV - 1);

  typedef enum logic [1:0] {
    MODE_TON = 2'd0,
    MODE_TOF = 2'd1,
    MODE_TP  = 2'd2,
    MODE_OFF = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    TP_IDLE  = 2'd0,
    TP_PULSE = 2'd1,
    TP_DONE  = 2'd2
  } tp_state_e;

  // Address decode
  logic [RW-1:0] reg_sel_c;
  logic [CW-1:0] ch_sel_c;
  logic          addr_err_c;
  logic          wr_c;
  logic          unused_addr_c;

  assign reg_sel_c     = paddr[2:0];
  assign ch_sel_c      = paddr[6:3];
  assign addr_err_c    = (32'(ch_sel_c) >= CH_N) || (reg_sel_c >= RW'(6));
  assign wr_c          = psel && penable && pwrite && !addr_err_c;
  assign unused_addr_c = ^paddr[APB_ADDR_W-1:7];

  assign pready  = 1'b1;
  assign pslverr = psel && penable && addr_err_c;

  // Free-running prescaler; tick on the last count of each period
  logic [PW-1:0] presc_cnt;
  logic          tick_c;

  assign tick_c = (presc_cnt == PRESC_LAST);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      presc_cnt <= '0;
    end else if (tick_c) begin
      presc_cnt <= '0;
    end else begin
      presc_cnt <= presc_cnt + PW'(1);
    end
  end

  // Per-channel views for the read mux
  logic [1:0]    type_arr [CH_N];
  logic [DW-1:0] pt_arr   [CH_N];
  logic [DW-1:0] et_arr   [CH_N];
  logic [CH_N-1:0] in_vec;
  logic [CH_N-1:0] q_vec;
  logic [CH_N-1:0] flag_vec;
`ifdef TMR_IRQ_EN
  logic [CH_N-1:0] flag_nxt_vec;
`endif

  for (genvar i = 0; i < CH_N; i++) begin : g_ch
    mode_e         type_q;
    logic [DW-1:0] pt_q;
    logic          in_q;
    logic          in_prev;
    tp_state_e     st_q;
    tp_state_e     st_nxt;
    logic [DW-1:0] et_q;
    logic [DW-1:0] et_nxt;
    logic          q_q;
    logic          q_nxt;
    logic          hit_c;
    logic          wr_type_c;
    logic          wr_pt_c;
    logic          wr_in_c;
    logic          et_ge_pt_c;
    logic [DW-1:0] et_inc_c;

    assign hit_c      = wr_c && (ch_sel_c == CW'(i));
    assign wr_type_c  = hit_c && (reg_sel_c == RW'(0));
    assign wr_pt_c    = hit_c && (reg_sel_c == RW'(1));
    assign wr_in_c    = hit_c && (reg_sel_c == RW'(2));
    assign et_ge_pt_c = (et_q >= pt_q);
    // Count one per tick but never past PT
    assign et_inc_c   = (tick_c && !et_ge_pt_c) ? et_q + DW'(1) : et_q;

    // Timer next-state; a TYPE write overrides everything with a clear
    always_comb begin
      st_nxt = st_q;
      et_nxt = et_q;
      q_nxt  = q_q;
      case (type_q)
        MODE_TON: begin
          st_nxt = TP_IDLE;
          if (!in_q) begin
            et_nxt = '0;
            q_nxt  = 1'b0;
          end else if (et_ge_pt_c) begin
            et_nxt = pt_q;
            q_nxt  = 1'b1;
          end else begin
            et_nxt = et_inc_c;
            q_nxt  = 1'b0;
          end
        end
        MODE_TOF: begin
          st_nxt = TP_IDLE;
          if (in_q) begin
            et_nxt = '0;
            q_nxt  = 1'b1;
          end else if (q_q) begin
            // Only a running off-delay counts; Q never rises while IN=0
            if (et_ge_pt_c) begin
              et_nxt = pt_q;
              q_nxt  = 1'b0;
            end else begin
              et_nxt = et_inc_c;
            end
          end else if (et_ge_pt_c) begin
            et_nxt = pt_q;
          end
        end
        MODE_TP: begin
          q_nxt = 1'b0;
          case (st_q)
            TP_IDLE: begin
              et_nxt = '0;
              if (in_q && !in_prev) begin
                st_nxt = TP_PULSE;
                q_nxt  = 1'b1;
              end
            end
            TP_PULSE: begin
              if (et_ge_pt_c) begin
                st_nxt = TP_DONE;
                et_nxt = pt_q;
              end else begin
                q_nxt  = 1'b1;
                et_nxt = et_inc_c;
              end
            end
            TP_DONE: begin
              if (!in_q) begin
                st_nxt = TP_IDLE;
                et_nxt = '0;
              end else if (et_ge_pt_c) begin
                et_nxt = pt_q;
              end
            end
            default: begin
              st_nxt = TP_IDLE;
              et_nxt = '0;
            end
          endcase
        end
        default: begin
          st_nxt = TP_IDLE;
          et_nxt = '0;
          q_nxt  = 1'b0;
        end
      endcase
      if (wr_type_c) begin
        st_nxt = TP_IDLE;
        et_nxt = '0;
        q_nxt  = 1'b0;
      end
    end

    // Channel registers and timer state
    always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
        type_q  <= MODE_OFF;
        pt_q    <= '0;
        in_q    <= 1'b0;
        in_prev <= 1'b0;
        st_q    <= TP_IDLE;
        et_q    <= '0;
        q_q     <= 1'b0;
      end else begin
        st_q    <= st_nxt;
        et_q    <= et_nxt;
        q_q     <= q_nxt;
        in_prev <= in_q;
        if (wr_type_c) type_q <= mode_e'(pwdata[1:0]);
        if (wr_pt_c)   pt_q   <= pwdata;
        if (wr_in_c)   in_q   <= pwdata[0];
      end
    end

`ifdef TMR_IRQ_EN
    logic wr_flag_c;
    logic flag_q;
    logic flag_nxt;

    assign wr_flag_c = hit_c && (reg_sel_c == RW'(5));
    // Set on Q rise wins over a same-cycle W1C
    assign flag_nxt  = (q_nxt && !q_q) || (flag_q && !(wr_flag_c && pwdata[0]));

    always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
        flag_q <= 1'b0;
      end else begin
        flag_q <= flag_nxt;
      end
    end

    assign flag_vec[i]     = flag_q;
    assign flag_nxt_vec[i] = flag_nxt;
`else
    assign flag_vec[i] = 1'b0;
`endif

    assign type_arr[i] = type_q;
    assign pt_arr[i]   = pt_q;
    assign et_arr[i]   = et_q;
    assign in_vec[i]   = in_q;
    assign q_vec[i]    = q_q;
  end

  assign tmr_q = q_vec;

`ifdef TMR_IRQ_EN
  // irq tracks the flags as they are being registered
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      irq <= 1'b0;
    end else begin
      irq <= |flag_nxt_vec;
    end
  end
`else
  assign irq = 1'b0;
`endif

  // Zero-wait read mux; bad addresses read 0
  always_comb begin
    prdata = '0;
    for (int i = 0; i < CH_N; i++) begin
      if (!addr_err_c && (ch_sel_c == CW'(i))) begin
        case (reg_sel_c)
          RW'(0):  prdata = {30'b0, type_arr[i]};
          RW'(1):  prdata = pt_arr[i];
          RW'(2):  prdata = {31'b0, in_vec[i]};
          RW'(3):  prdata = {31'b0, q_vec[i]};
          RW'(4):  prdata = et_arr[i];
          RW'(5):  prdata = {31'b0, flag_vec[i]};
          default: prdata = '0;
        endcase
      end
    end
  end

endmodule
